// File: rtl/dmem_port_arbiter.sv
// Two-port req/ack arbiter sharing one single-ported data memory with a fixed read latency.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [31:0]       addr0,
  input  logic [31:0]       addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [31:0]       mem_write_val,
  input  logic [31:0]       mem_read_val
);

  if (RD_LATENCY < 1 || RD_LATENCY > 15) begin : g_bad_latency
    $error("dmem_port_arbiter: RD_LATENCY must be in 1..15");
  end
  if (ADDR_W < 1 || ADDR_W > 29) begin : g_bad_addr_w
    $error("dmem_port_arbiter: ADDR_W must be in 1..29");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]        wait_cnt;
  logic              wait_last;
  logic              gnt_port;
  logic              gnt_we;
  logic              grant;
  logic              sel_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_maddr;
  logic [31:0]       sel_wdata;

  // Byte offset and bits above the memory's word range never reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr0[31:ADDR_W+2], addr0[1:0], addr1[31:ADDR_W+2], addr1[1:0]};

  assign grant     = (state == S_IDLE) && (req0 || req1);
  assign wait_last = (wait_cnt == 4'd0);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  // last_port = port granted most recently; on contention the other port wins.
  logic last_port;

  always_comb begin
    if (req0 && req1) sel_port = ~last_port;
    else              sel_port = ~req0;
  end

  always_ff @(posedge clk) begin
    if (reset)      last_port <= 1'b1;
    else if (grant) last_port <= sel_port;
  end
`else
  always_comb sel_port = ~req0;
`endif

  assign sel_we    = sel_port ? we1 : we0;
  assign sel_maddr = sel_port ? addr1[ADDR_W+1:2] : addr0[ADDR_W+1:2];
  assign sel_wdata = sel_port ? wdata1 : wdata0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: always_comb assigns a default first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req0 || req1) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = gnt_we ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because every output must read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_port      <= 1'b0;
      gnt_we        <= 1'b0;
      wait_cnt      <= 4'd0;
      mem_addr      <= '0;
      mem_write_val <= '0;
      rdata0        <= '0;
      rdata1        <= '0;
    end else begin
      // mem_addr / mem_write_val load at grant so they appear in ISSUE and hold until the next one.
      if (grant) begin
        gnt_port <= sel_port;
        gnt_we   <= sel_we;
        mem_addr <= sel_maddr;
        if (sel_we) mem_write_val <= sel_wdata;
      end
      if (state == S_ISSUE)                wait_cnt <= 4'(RD_LATENCY - 1);
      else if (state == S_WAIT && !wait_last) wait_cnt <= wait_cnt - 4'd1;
      if (state == S_WAIT && wait_last) begin
        if (gnt_port) rdata1 <= mem_read_val;
        else          rdata0 <= mem_read_val;
      end
    end
  end

  always_comb begin
    mem_read_en  = (state == S_ISSUE) && !gnt_we;
    mem_write_en = (state == S_ISSUE) &&  gnt_we;
    ack0         = (state == S_DONE)  && !gnt_port;
    ack1         = (state == S_DONE)  &&  gnt_port;
    busy         = (state != S_IDLE);
  end

endmodule
